dual_jk: RTL and testbench



---
 rtl/dual_jk_if.sv | 24 ++
 rtl/dual_jk.sv | 23 ++
 tb/tb_dual_jk.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dual_jk_if.sv
// Data-side signals of the JK flip-flop bank: per-bit J/K inputs and true/complement outputs.
// The master drives J/K and observes Q/Q_n; the slave is the flop bank itself.
interface dual_jk_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_n;

    modport master (
        output J,
        output K,
        input  Q,
        input  Q_n
    );

    modport slave (
        input  J,
        input  K,
        output Q,
        output Q_n
    );
endinterface

// File: rtl/dual_jk.sv
// Bank of WIDTH independent positive-edge JK flip-flops sharing one clock and one
// asynchronous active-low clear, in the style of the 74xx107/112 dual JK part.
module dual_jk #(
    parameter int WIDTH = 1
) (
    input logic       clk,
    input logic       clr_n,
    dual_jk_if.slave  bus
);
    logic [WIDTH-1:0] state;

    // Per bit: J sets a cleared bit and K clears a set bit, so J=K=1 toggles and J=K=0 holds.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= '0;
        end else begin
            state <= (bus.J & ~state) | (~bus.K & state);
        end
    end

    assign bus.Q   = state;
    assign bus.Q_n = ~state;
endmodule

// File: tb/tb_dual_jk.sv
// Scoreboarded bench for dual_jk: a single-bit instance and a 4-bit instance share clk and clr_n.
// Stimulus pushes hand-computed expected Q values; a monitor pops and compares against the DUT.
module tb_dual_jk;
    typedef struct {
        string      name;
        bit         wide;
        logic [3:0] q;
        logic [3:0] qn;
    } exp_t;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_queue[$];

    dual_jk_if #(.WIDTH(1)) nbus ();
    dual_jk_if #(.WIDTH(4)) wbus ();

    dual_jk #(.WIDTH(1)) dut_narrow (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (nbus.slave)
    );

    dual_jk #(.WIDTH(4)) dut_wide (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (wbus.slave)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge so every rising edge sees settled J/K.
    task automatic applyStimulus(input bit wide, input logic [3:0] j, input logic [3:0] k);
        @(negedge clk);
        if (wide) begin
            wbus.J = j;
            wbus.K = k;
        end else begin
            nbus.J = j[0];
            nbus.K = k[0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit wide, input logic [3:0] q);
        exp_t e;
        e.name = name;
        e.wide = wide;
        e.q    = wide ? q : {3'b000, q[0]};
        e.qn   = wide ? ~q : {3'b000, ~q[0]};
        exp_queue.push_back(e);
        wait (exp_queue.size() == 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (exp_queue.size() != 0);
            e = exp_queue.pop_front();
            checks++;
            if (e.wide) begin
                if (wbus.Q !== e.q || wbus.Q_n !== e.qn) begin
                    errors++;
                    $display("[TB] FAIL %s: Q=%b Q_n=%b, required Q=%b Q_n=%b",
                             e.name, wbus.Q, wbus.Q_n, e.q, e.qn);
                end
            end else begin
                if (nbus.Q !== e.q[0] || nbus.Q_n !== e.qn[0]) begin
                    errors++;
                    $display("[TB] FAIL %s: Q=%b Q_n=%b, required Q=%b Q_n=%b",
                             e.name, nbus.Q, nbus.Q_n, e.q[0], e.qn[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        nbus.J = 1'b0;
        nbus.K = 1'b0;
        wbus.J = 4'b0000;
        wbus.K = 4'b0000;

        // Clear takes effect with no clock edge at all.
        #1 clr_n = 1'b0;
        #1;
        checkOutput("clear_async_narrow", 1'b0, 4'h0);
        checkOutput("clear_async_wide",   1'b1, 4'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("clear_held", 1'b0, 4'h0);
        end

        @(negedge clk);
        clr_n = 1'b1;
        #1;
        checkOutput("clear_release_no_change", 1'b0, 4'h0);
        tick();
        checkOutput("hold_zero", 1'b0, 4'h0);

        applyStimulus(1'b0, 4'h1, 4'h0);
        tick();
        checkOutput("set", 1'b0, 4'h1);
        applyStimulus(1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_one", 1'b0, 4'h1);
        end
        applyStimulus(1'b0, 4'h0, 4'h1);
        tick();
        checkOutput("reset", 1'b0, 4'h0);

        applyStimulus(1'b0, 4'h1, 4'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("toggle", 1'b0, (i % 2 == 0) ? 4'h1 : 4'h0);
        end

        // Clear dropped between edges while toggling from Q=1.
        tick();
        checkOutput("toggle_to_one", 1'b0, 4'h1);
        #2 clr_n = 1'b0;
        #1;
        checkOutput("clear_mid_op", 1'b0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("clear_mid_op_held", 1'b0, 4'h0);
        end
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        checkOutput("release_mid_op", 1'b0, 4'h0);
        tick();
        checkOutput("toggle_after_release", 1'b0, 4'h1);

        applyStimulus(1'b1, 4'b1010, 4'b0101);
        tick();
        checkOutput("wide_set_reset", 1'b1, 4'b1010);
        applyStimulus(1'b1, 4'b1111, 4'b1111);
        tick();
        checkOutput("wide_toggle", 1'b1, 4'b0101);
        applyStimulus(1'b1, 4'b0001, 4'b0001);
        tick();
        checkOutput("wide_bit0_only", 1'b1, 4'b0100);
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        tick();
        checkOutput("wide_hold", 1'b1, 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
